uart_rx_core: RTL

UART receive path: deserialises 8N1 frames from the `rxd` line using 16x oversampling and presents each byte to the host with a receive-data-register-full (`rdrf`) flag. It is the receive counterpart of the button-driven transmit controller and UART transmitter. The host clears `rdrf` through a one-cycle handshake, and the block reports framing, overrun and (optionally) parity errors.

---
 rtl/uart_rx_core_if.sv | 12 +
 rtl/uart_rx_core.sv | 130 +++++++++++++
 2 files changed

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: serial line, host handshake and status bundle for the UART receiver
interface uart_rx_core_if;
  logic       rxd;
  logic       rdrf_clr;
  logic [7:0] rx_data;
  logic       rdrf;
  logic       fe;
  logic       oe;
  logic       pe;
  modport master (output rxd, rdrf_clr, input rx_data, rdrf, fe, oe, pe);
  modport slave  (input rxd, rdrf_clr, output rx_data, rdrf, fe, oe, pe);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled 8N1 receiver with rdrf/fe/oe flags; even parity frame when UART_RX_PARITY_EN is defined
module uart_rx_core #(
  parameter int BAUD_DIV = 27
) (
  input logic           clk,
  input logic           clr,
  uart_rx_core_if.slave bus
);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam state_t S_AFTER_DATA = S_STOP;
`endif
  state_t      r_state;
  logic [1:0]  r_sync;
  logic [15:0] r_tcnt;
  logic [3:0]  r_scnt;
  logic [2:0]  r_bcnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rdrf;
  logic        r_fe;
  logic        r_oe;
  logic        w_rxs;
  logic        w_tick;
`ifdef UART_RX_PARITY_EN
  logic        r_perr;
  logic        r_pe;
`endif
  assign w_rxs  = r_sync[1];
  assign w_tick = (r_state != S_IDLE) && (r_tcnt == 16'(BAUD_DIV - 1));
  assign bus.rx_data = r_rx_data;
  assign bus.rdrf    = r_rdrf;
  assign bus.fe      = r_fe;
  assign bus.oe      = r_oe;
`ifdef UART_RX_PARITY_EN
  assign bus.pe      = r_pe;
`else
  assign bus.pe      = 1'b0;
`endif
  // two-flop synchroniser for the asynchronous line; resets to the idle level
  always_ff @(posedge clk or negedge clr)
    if (!clr) r_sync <= 2'b11;
    else      r_sync <= {r_sync[0], bus.rxd};
  // receive FSM: oversample timing, bit assembly, frame completion and host flags
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= S_IDLE;
      r_tcnt    <= '0;
      r_scnt    <= '0;
      r_bcnt    <= '0;
      r_shift   <= '0;
      r_rx_data <= '0;
      r_rdrf    <= 1'b0;
      r_fe      <= 1'b0;
      r_oe      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
      r_pe      <= 1'b0;
`endif
    end else begin
      r_tcnt <= (r_state == S_IDLE || w_tick) ? '0 : r_tcnt + 16'd1;
      if (bus.rdrf_clr) begin
        r_rdrf <= 1'b0;
        r_fe   <= 1'b0;
        r_oe   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_pe   <= 1'b0;
`endif
      end
      case (r_state)
        S_IDLE:
          if (!w_rxs) begin
            r_state <= S_START;
            r_scnt  <= '0;
          end
        // mid start bit decides between a real frame and a glitch
        S_START:
          if (w_tick) begin
            r_scnt <= (r_scnt == 4'd7) ? '0 : r_scnt + 4'd1;
            if (r_scnt == 4'd7) begin
              r_state <= w_rxs ? S_IDLE : S_DATA;
              r_bcnt  <= '0;
            end
          end
        S_DATA:
          if (w_tick) begin
            r_scnt <= r_scnt + 4'd1;
            if (r_scnt == 4'd15) begin
              r_shift <= {w_rxs, r_shift[7:1]};
              r_bcnt  <= r_bcnt + 3'd1;
              if (r_bcnt == 3'd7) r_state <= S_AFTER_DATA;
            end
          end
`ifdef UART_RX_PARITY_EN
        S_PARITY:
          if (w_tick) begin
            r_scnt <= r_scnt + 4'd1;
            if (r_scnt == 4'd15) begin
              r_perr  <= ^{r_shift, w_rxs};
              r_state <= S_STOP;
            end
          end
`endif
        // mid stop bit: deliver the byte (a coincident host clear loses to the new frame)
        S_STOP:
          if (w_tick) begin
            r_scnt <= r_scnt + 4'd1;
            if (r_scnt == 4'd15) begin
              r_state <= S_IDLE;
              if (!r_rdrf || bus.rdrf_clr) begin
                r_rx_data <= r_shift;
                r_rdrf    <= 1'b1;
                r_fe      <= !w_rxs;
                r_oe      <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_pe      <= r_perr;
`endif
              end else begin
                r_oe <= 1'b1;
              end
            end
          end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
